// File: rtl/prog_image_loader.sv
// Byte-stream loader for the accumulator CPU image bus: sync, 32 payload bytes, checksum,
// then a registered initial_load pulse with stable init_ins/init_data.
module prog_image_loader #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         LOAD_CYCLES = 2,
    parameter int         TIMEOUT     = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] init_ins,
    output logic [127:0] init_data,
    output logic         initial_load,
    output logic         cpu_hold,
    output logic         busy,
    output logic         done,
    output logic         csum_err,
    output logic         frame_err
);

    localparam logic [3:0]  LOAD_CNT_INIT = 4'(LOAD_CYCLES);
    localparam logic [15:0] TIMEOUT_W     = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CSUM,
        ST_LOAD
    } state_t;

    state_t         state_q;
    logic [4:0]     idx_q;
    logic [7:0]     sum_q;
    logic [255:0]   shadow_q;
    logic [3:0]     load_cnt_q;
    logic [15:0]    idle_cnt_q;
    logic [127:0]   init_ins_q;
    logic [127:0]   init_data_q;
    logic           initial_load_q;
    logic           cpu_hold_q;
    logic           busy_q;
    logic           done_q;
    logic           csum_err_q;
    logic           frame_err_q;

    logic           accept;
    logic [7:0]     sum_d;
    logic [15:0]    idle_cnt_d;
    logic           timeout_hit;

    assign in_ready    = !reset && (state_q != ST_LOAD);
    assign accept      = in_valid && in_ready;
    assign sum_d       = sum_q + in_data;
    assign idle_cnt_d  = idle_cnt_q + 16'd1;
    // An accepted byte always wins over the timeout on the same edge.
    assign timeout_hit = (TIMEOUT != 0) && !accept && (idle_cnt_d == TIMEOUT_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            sum_q          <= '0;
            shadow_q       <= '0;
            load_cnt_q     <= '0;
            idle_cnt_q     <= '0;
            init_ins_q     <= '0;
            init_data_q    <= '0;
            initial_load_q <= 1'b0;
            cpu_hold_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            csum_err_q     <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && (in_data == SYNC_BYTE)) begin
                        state_q     <= ST_PAYLOAD;
                        idx_q       <= '0;
                        sum_q       <= '0;
                        idle_cnt_q  <= '0;
                        busy_q      <= 1'b1;
                        cpu_hold_q  <= 1'b1;
                        done_q      <= 1'b0;
                        csum_err_q  <= 1'b0;
                        frame_err_q <= 1'b0;
                    end
                end

                ST_PAYLOAD: begin
                    if (accept) begin
                        shadow_q[{idx_q, 3'b000} +: 8] <= in_data;
                        sum_q      <= sum_d;
                        idx_q      <= idx_q + 5'd1;
                        idle_cnt_q <= '0;
                        if (idx_q == 5'd31) begin
                            state_q <= ST_CSUM;
                        end
                    end else if (timeout_hit) begin
                        state_q     <= ST_IDLE;
                        frame_err_q <= 1'b1;
                        busy_q      <= 1'b0;
                        cpu_hold_q  <= 1'b0;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end

                ST_CSUM: begin
                    if (accept) begin
                        idle_cnt_q <= '0;
                        if (sum_d == 8'h00) begin
                            init_ins_q     <= shadow_q[127:0];
                            init_data_q    <= shadow_q[255:128];
                            initial_load_q <= 1'b1;
                            load_cnt_q     <= LOAD_CNT_INIT;
                            state_q        <= ST_LOAD;
                        end else begin
                            csum_err_q <= 1'b1;
                            busy_q     <= 1'b0;
                            cpu_hold_q <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
                    end else if (timeout_hit) begin
                        state_q     <= ST_IDLE;
                        frame_err_q <= 1'b1;
                        busy_q      <= 1'b0;
                        cpu_hold_q  <= 1'b0;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end

                ST_LOAD: begin
                    load_cnt_q <= load_cnt_q - 4'd1;
                    if (load_cnt_q == 4'd1) begin
                        initial_load_q <= 1'b0;
                        cpu_hold_q     <= 1'b0;
                        busy_q         <= 1'b0;
                        done_q         <= 1'b1;
                        state_q        <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign init_ins     = init_ins_q;
    assign init_data    = init_data_q;
    assign initial_load = initial_load_q;
    assign cpu_hold     = cpu_hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign csum_err     = csum_err_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_prog_image_loader.sv
// Directed bench for prog_image_loader: good/bad frames, timeout, garbage,
// backpressure during LOAD and reset in the middle of LOAD.
module tb_prog_image_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] init_ins;
    logic [127:0] init_data;
    logic         initial_load;
    logic         cpu_hold;
    logic         busy;
    logic         done;
    logic         csum_err;
    logic         frame_err;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] INS_A = 128'h0F0E0D0C0B0A09080706050403020140;
    localparam logic [127:0] DAT_A = 128'h0000000000000000000000000000000A;
    localparam logic [127:0] INS_B = 128'h0F0E0D0C0B0A090807060504A5020140;
    localparam logic [127:0] DAT_B = 128'h0000000000000000000000000000000B;
    localparam logic [127:0] INS_C = {16{8'h11}};
    localparam logic [127:0] DAT_C = {16{8'h22}};

    prog_image_loader #(
        .SYNC_BYTE  (8'hA5),
        .LOAD_CYCLES(2),
        .TIMEOUT    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .init_ins    (init_ins),
        .init_data   (init_data),
        .initial_load(initial_load),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .csum_err    (csum_err),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_wait", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_payload(input logic [127:0] ins, input logic [127:0] dat, input logic [7:0] csum);
        for (int i = 0; i < 16; i++) send_byte(ins[i*8 +: 8]);
        for (int i = 0; i < 16; i++) send_byte(dat[i*8 +: 8]);
        send_byte(csum);
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after the checksum edge; counts initial_load cycles and checks image stability.
    task automatic watch_load(input logic [127:0] ins, input logic [127:0] dat);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (initial_load) begin
                n++;
                check("load_ins_stable", init_ins, ins);
                check("load_dat_stable", init_data, dat);
            end else if (n > 0) begin
                break;
            end
            @(posedge clk);
            #1;
        end
        check("load_len", n, 2);
        check("load_done", done, 1);
        check("load_hold_drop", cpu_hold, 0);
        check("load_busy_drop", busy, 0);
    endtask

    initial begin
        int n_nr;
        int n_ld;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_load", initial_load, 0);
        check("rst_ins", init_ins, 0);
        check("rst_dat", init_data, 0);
        check("rst_flags", {cpu_hold, busy, done, csum_err, frame_err}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", in_ready, 1);

        // good frame
        send_byte(8'hA5);
        check("sync_busy", busy, 1);
        check("sync_hold", cpu_hold, 1);
        send_payload(INS_A, DAT_A, 8'h3E);
        check("good_load_hi", initial_load, 1);
        check("good_not_ready", in_ready, 0);
        check("good_ins_b0", init_ins[7:0], 8'h40);
        check("good_dat_b0", init_data[7:0], 8'h0A);
        watch_load(INS_A, DAT_A);
        check("good_ins", init_ins, INS_A);
        check("good_dat", init_data, DAT_A);

        // bad checksum
        send_byte(8'hA5);
        check("bad_done_clr", done, 0);
        send_payload(INS_C, DAT_C, 8'hD1);
        check("bad_csum_err", csum_err, 1);
        check("bad_busy", busy, 0);
        check("bad_hold", cpu_hold, 0);
        n_ld = 0;
        for (int i = 0; i < 4; i++) begin
            if (initial_load) n_ld++;
            @(posedge clk);
            #1;
        end
        check("bad_no_pulse", n_ld, 0);
        check("bad_ins_kept", init_ins, INS_A);
        check("bad_dat_kept", init_data, DAT_A);

        // timeout, including a byte arriving on the edge the counter would expire
        send_byte(8'hA5);
        check("to_csum_clr", csum_err, 0);
        for (int i = 0; i < 5; i++) send_byte(8'h11);
        idle_cycles(3);
        check("to_busy_3idle", busy, 1);
        for (int i = 0; i < 5; i++) send_byte(8'h11);
        check("to_byte_wins", busy, 1);
        idle_cycles(3);
        check("to_busy_pre", busy, 1);
        check("to_ferr_pre", frame_err, 0);
        idle_cycles(1);
        check("to_ferr", frame_err, 1);
        check("to_busy", busy, 0);
        check("to_hold", cpu_hold, 0);
        check("to_ins_kept", init_ins, INS_A);

        // garbage before sync, embedded sync in payload
        send_byte(8'h00);
        send_byte(8'h33);
        check("garb_busy", busy, 0);
        check("garb_ferr_kept", frame_err, 1);
        send_byte(8'hA5);
        send_payload(INS_B, DAT_B, 8'h9B);
        check("emb_ins_b3", init_ins[31:24], 8'hA5);
        check("emb_load_hi", initial_load, 1);

        // backpressure: sync of next frame held valid through LOAD
        n_nr = 0;
        n_ld = 0;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (initial_load) n_ld++;
            if (!in_ready) n_nr++;
            else break;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_not_ready", n_nr, 2);
        check("bp_load_len", n_ld, 2);
        check("bp_sync_taken", busy, 1);
        check("bp_ins", init_ins, INS_B);
        check("bp_dat", init_data, DAT_B);
        send_payload(INS_C, DAT_C, 8'hD0);
        watch_load(INS_C, DAT_C);
        check("bp2_ins", init_ins, INS_C);
        check("bp2_dat", init_data, DAT_C);

        // reset in first LOAD cycle
        send_byte(8'hA5);
        send_payload(INS_A, DAT_A, 8'h3E);
        check("rl_load_hi", initial_load, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rl_load", initial_load, 0);
        check("rl_ins", init_ins, 0);
        check("rl_dat", init_data, 0);
        check("rl_flags", {cpu_hold, busy, done, csum_err, frame_err}, 0);
        check("rl_ready", in_ready, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_image_loader.md
# prog_image_loader

Byte-stream program loader that sits in front of the accumulator CPU and drives its 128-bit `init_ins` and `init_data` image buses and its `initial_load` strobe. It is the producer end of the CPU's image-load interface.

- A host or testbench streams one framed image per load: sync byte, 16 instruction bytes, 16 data bytes, checksum.
- Images that fail the checksum, or stall mid-frame, never reach the CPU.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `LOAD_CYCLES`, default 2: number of cycles `initial_load` is held high; legal range 1..15.
- `TIMEOUT`, default 255: idle cycles allowed mid-frame before abort; 0 disables the timeout.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `in_data`  in  8: stream byte.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: loader can accept a byte.
- `init_ins`  out  128: instruction image; byte i is at bits [i*8+:8].
- `init_data`  out  128: data image; same byte mapping as `init_ins`.
- `initial_load`  out  1: CPU image-load strobe.
- `cpu_hold`  out  1: CPU must not execute while this is high.
- `busy`  out  1: a frame is in progress.
- `done`  out  1: sticky; last frame committed.
- `csum_err`  out  1: sticky; last frame had a bad checksum.
- `frame_err`  out  1: sticky; last frame timed out.

## Operation
- **Handshake.** A byte is accepted on a rising edge where `in_valid && in_ready`.
  - `in_ready` = !reset && state != LOAD.
  - `in_data` is ignored when no byte is accepted.
- **States.** IDLE, PAYLOAD, CSUM, LOAD.
- **IDLE.**
  - An accepted byte equal to `SYNC_BYTE` moves to PAYLOAD; on the same edge: `idx`=0, `sum`=0, `busy`=1, `cpu_hold`=1, and `done`, `csum_err`, `frame_err` all clear.
  - Any other accepted byte is discarded; no flag changes.
- **PAYLOAD.**
  - Each accepted byte goes to shadow byte `idx`. Shadow slots 0..15 hold the instruction image; slots 16..31 hold the data image.
  - On the same edge: `sum` += byte (mod 256) and `idx`++.
  - The edge that accepts `idx`=31 moves to CSUM.
  - A byte equal to `SYNC_BYTE` inside the payload is ordinary data.
- **CSUM.** The accepted byte `c` is checked against `sum + c == 8'h00` (mod 256).
  - Pass, on the same edge: shadow copies to `init_ins`/`init_data`, `initial_load`=1, load counter = `LOAD_CYCLES`, go to LOAD.
  - Fail, on the same edge: `csum_err`=1, `busy`=0, `cpu_hold`=0, go to IDLE. `init_*` are unchanged.
- **LOAD.**
  - The counter decrements each cycle.
  - On the edge where it reaches 0: `initial_load`=0, `cpu_hold`=0, `busy`=0, `done`=1, go to IDLE.
- **Timeout.**
  - Applies in PAYLOAD and CSUM, with `TIMEOUT`≠0.
  - An idle counter clears on every accepted byte and increments on every cycle without one.
  - When it reaches `TIMEOUT`: `frame_err`=1, `busy`=0, `cpu_hold`=0, go to IDLE; `init_*` are unchanged.
- **Output stability.** `init_*` change only on a checksum-pass edge, and hold otherwise, including across aborted frames.

## Timing
- **Reset values.** All outputs are 0. `init_ins`=0, `init_data`=0, shadow=0, state=IDLE. `in_ready` is 0 while `reset` is high.
- **Reset mid-frame or mid-LOAD.** Takes effect on the next edge: `initial_load` drops, `init_*` clear to 0, every partial frame is dropped.
- **Throughput.** One byte per cycle. A back-to-back frame of 34 bytes (sync + 32 + csum) has its checksum accepted at edge E.
  - `initial_load` is high for cycles E+1..E+`LOAD_CYCLES`.
  - `done` rises at edge E+`LOAD_CYCLES`.
  - A new sync byte can be accepted on the following edge.
- **Glitch-free load.** `init_*` are stable for the whole time `initial_load` is high. The CPU samples them on every posedge within that window.
- **Simultaneous events.** On the edge that reaches `TIMEOUT`, a byte accepted on that same edge takes priority: the byte is accepted and the counter clears.

## Test plan
- **Good frame.** Stream A5, ins bytes 0x40,0x01,…,0x0F, data 0x0A,0x00×15, correct csum.
  - `init_ins[7:0]`=0x40 and `init_data[7:0]`=0x0A.
  - `initial_load` is high exactly 2 cycles, then `done`=1.
- **Bad checksum.** Load the good frame, then send a second frame with csum+1.
  - `csum_err`=1, no `initial_load` pulse.
  - `init_*` still equal the first frame.
- **Timeout.** Use `TIMEOUT`=4. Send A5 plus 10 payload bytes, then drop `in_valid` for 4 cycles.
  - `frame_err`=1, `busy`=0.
  - A subsequent good frame then loads correctly.
- **Garbage and embedded sync.** Send 0x00,0x33 before A5, and put 0xA5 at payload byte 3.
  - The leading bytes are discarded.
  - `init_ins[31:24]`=0xA5 and the frame commits.
- **Backpressure.** Hold `in_valid`=1 during LOAD.
  - `in_ready`=0 for `LOAD_CYCLES` cycles, no byte is lost.
  - A frame streamed immediately after commits correctly.
- **Reset mid-LOAD.** Assert `reset` in the first LOAD cycle.
  - The next edge gives `initial_load`=0, `init_*`=0, `cpu_hold`=0, and all flags 0.
